sumador_serie_ctrl: RTL

// - Sequencer that computes a WIDTH-bit add by reusing one 2-bit ripple-adder slice.
//   It processes 2 bits per cycle, LSB pair first, carrying between cycles in a register.
// - Trades area for latency in the ALU datapath: one slice instead of WIDTH/2 chained slices.
// - Start/busy/done handshake toward the ALU top-level operation decoder.

---
 rtl/sumador_pkg.sv | 29 ++
 rtl/sumador_serie_ctrl_slice.sv | 31 +++
 rtl/sumador_serie_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
// ============================================================================
// Module : sumador_pkg
// Brief  : Shared constants and state type for the serial adder sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

    localparam int SLICE_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_RUN  = ST_RUN,
        STATE_DONE = ST_DONE
    } state_t;

    // Pair counter width, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return ((width / SLICE_W) > 1) ? $clog2(width / SLICE_W) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sumador_serie_ctrl_slice.sv
// ============================================================================
// Module : Sumador_1
// Brief  : 2-bit ripple-carry adder slice reused by the serial sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module Sumador_1
    import sumador_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               C_in,
    output logic [SLICE_W-1:0] S,
    output logic               C_out
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = C_in;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign C_out = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/sumador_serie_ctrl.sv
// ============================================================================
// Module : sumador_serie_ctrl
// Brief  : WIDTH-bit adder built from one 2-bit slice, 2 bits per cycle.
//          Optional subtract mode (A - B) enabled by macro SUMADOR_SERIE_SUB_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sumador_serie_ctrl
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
`ifdef SUMADOR_SERIE_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);

    localparam int             NPAIRS = WIDTH / SLICE_W;
    localparam int             CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAIRS - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("sumador_serie_ctrl: WIDTH must be even and >= 2");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic [SLICE_W-1:0] w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

`ifdef SUMADOR_SERIE_SUB_EN
    // Subtraction as A + ~B + 1; the incoming carry is overridden.
    assign w_b_load = sub ? ~B : B;
    assign w_c_load = sub ? 1'b1 : C_in;
`else
    assign w_b_load = B;
    assign w_c_load = C_in;
`endif

    Sumador_1 u_slice (
        .A     (r_a[SLICE_W-1:0]),
        .B     (r_b[SLICE_W-1:0]),
        .C_in  (r_carry),
        .S     (w_sum),
        .C_out (w_carry)
    );

    // New pair enters at the MSB end; the oldest pair settles at the LSB end.
    assign w_acc_next = WIDTH'({w_sum, r_acc} >> SLICE_W);
    assign w_last     = (r_cnt == LAST_CNT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE: if (start) w_state_next = STATE_RUN;
            STATE_RUN:  if (w_last) w_state_next = STATE_DONE;
            STATE_DONE: w_state_next = STATE_IDLE;
            default:    w_state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                    end
                end
                STATE_RUN: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s    <= w_acc_next;
                        r_cout <= w_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state == STATE_RUN);
    assign done  = (r_state == STATE_DONE);
    assign S     = r_s;
    assign C_out = r_cout;

endmodule

`default_nettype wire
